// File: rtl/operand_loader.sv
// Operand loader: collects NUM_OPS words into a fill bank, then hands them to the
// mul/alu controller as a stable active bank with a one-cycle start pulse.
module operand_loader #(
    parameter int WIDTH   = 16,
    parameter int NUM_OPS = 7,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    input  logic                     op_ready,
    input  logic                     done_next,
    output logic                     start,
    output logic [NUM_OPS*WIDTH-1:0] operands,
    output logic                     busy,
    output logic [CNT_W-1:0]         batch_count,
    output logic                     protocol_err
);

    localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    typedef enum logic [1:0] {L_IDLE, L_START, L_RUN} lstate_t;

    lstate_t                  state_q;
    logic [NUM_OPS*WIDTH-1:0] fill_q, fill_d;
    logic [NUM_OPS*WIDTH-1:0] active_q;
    logic [IDX_W-1:0]         wr_idx_q, wr_idx_d;
    logic                     fill_full_q, fill_full_d;
    logic [CNT_W-1:0]         batch_count_q;
    logic                     start_q, busy_q, perr_q;
    logic                     accept, launch, last_word;

    assign in_ready     = rst & ~fill_full_q;
    assign accept       = in_valid & in_ready;
    assign launch       = (state_q == L_IDLE) & fill_full_q & op_ready;
    assign last_word    = (wr_idx_q == IDX_W'(NUM_OPS - 1));

    assign start        = start_q;
    assign busy         = busy_q;
    assign operands     = active_q;
    assign batch_count  = batch_count_q;
    assign protocol_err = perr_q;

    // Fill side: in_ready is low while the bank is full, so accept and launch never coincide.
    always_comb begin
        fill_d      = fill_q;
        wr_idx_d    = wr_idx_q;
        fill_full_d = fill_full_q;
        if (accept) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                if (wr_idx_q == IDX_W'(i)) begin
                    fill_d[i*WIDTH +: WIDTH] = in_data;
                end
            end
            if (last_word) begin
                wr_idx_d    = '0;
                fill_full_d = 1'b1;
            end else begin
                wr_idx_d = wr_idx_q + IDX_W'(1);
            end
        end
        if (launch) begin
            fill_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_q      <= '0;
            wr_idx_q    <= '0;
            fill_full_q <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            wr_idx_q    <= wr_idx_d;
            fill_full_q <= fill_full_d;
        end
    end

    // Launch FSM with registered start/busy; the active bank only moves on the launch edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= L_IDLE;
            active_q      <= '0;
            batch_count_q <= '0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            perr_q        <= 1'b0;
        end else begin
            case (state_q)
                L_IDLE: begin
                    if (done_next) begin
                        perr_q <= 1'b1;
                    end
                    if (launch) begin
                        active_q <= fill_q;
                        state_q  <= L_START;
                        start_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                L_START: begin
                    if (done_next) begin
                        perr_q <= 1'b1;
                    end
                    start_q <= 1'b0;
                    state_q <= L_RUN;
                end
                L_RUN: begin
                    if (done_next) begin
                        batch_count_q <= batch_count_q + CNT_W'(1);
                        state_q       <= L_IDLE;
                        busy_q        <= 1'b0;
                    end
                end
                default: begin
                    state_q <= L_IDLE;
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream feeder for the scheduled mul/alu datapath controller.
- Collects NUM_OPS primary operands from a valid/ready input stream into a fill bank.
- Once the bank is full and the controller reports op_ready, copies the fill bank into a stable active bank and issues a one-cycle start pulse.
- Holds the active bank constant until the controller returns done_next. The fill bank refills meanwhile, so batches can run back-to-back.

Parameters:
WIDTH, 16, operand word width
NUM_OPS, 7, primary operands per batch (datapath select codes 0..NUM_OPS-1)
CNT_W, 8, width of completed-batch counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-low reset; 0 = reset asserted
in_valid  in  1  input operand word valid
in_data  in  WIDTH  input operand word; words arrive in operand index order 0..NUM_OPS-1
in_ready  out  1  loader can accept a word this cycle
op_ready  in  1  controller is idle and can accept start
done_next  in  1  controller batch-complete pulse
start  out  1  one-cycle launch pulse to controller
operands  out  NUM_OPS*WIDTH  active bank; operand i occupies bits [i*WIDTH +: WIDTH]
busy  out  1  a batch is launched and not yet completed
batch_count  out  CNT_W  number of completed batches, wraps modulo 2^CNT_W
protocol_err  out  1  sticky flag: done_next received when no batch was in flight

Behaviour:
- Reset (rst==0 at posedge):
  - fill bank, active bank, operands, wr_idx, fill_full, batch_count, protocol_err all cleared to 0.
  - start=0, busy=0, launch FSM to L_IDLE.
  - in_ready is forced 0 while rst==0.
  - Reset mid-fill or mid-run discards all data; no start is issued afterwards until a fresh full batch is loaded.
- Fill side:
  - in_ready = rst & ~fill_full (combinational).
  - Handshake fires when in_valid & in_ready at a posedge: fill[wr_idx] <= in_data.
  - If wr_idx==NUM_OPS-1: wr_idx <= 0 and fill_full <= 1; otherwise wr_idx <= wr_idx+1.
  - in_valid may be held or dropped at any cycle; gaps cost no state.
- Launch FSM (states L_IDLE, L_START, L_RUN):
  - L_IDLE:
    - Launch condition: fill_full & op_ready at a posedge.
    - On launch: active <= fill, fill_full <= 0, go to L_START.
    - Launch has priority; no input handshake can occur on the launch cycle because in_ready is 0 while fill_full.
  - L_START:
    - start=1 for exactly this one cycle; busy=1; unconditionally go to L_RUN.
  - L_RUN:
    - busy=1; wait for done_next.
    - On done_next: batch_count <= batch_count+1 (wrapping), then go to L_IDLE.
  - start and busy are registered state decodes. busy=1 in L_START and L_RUN, 0 in L_IDLE.
- Timing:
  - Latency from the last word accepted to start high is 2 cycles, given op_ready is already 1.
  - in_ready rises the cycle after launch, so the next batch fills while L_RUN is active.
  - A fully prefilled bank launches on the first cycle after done_next at which op_ready=1. Back-to-back batches have no gap beyond the controller's IDLE cycle.
- operands:
  - Changes only on the launch edge; stable throughout L_START and L_RUN.
- protocol_err:
  - Set when done_next=1 in L_IDLE or L_START.
  - Cleared only by reset; state otherwise unaffected.
- op_ready low in L_IDLE with fill_full: wait indefinitely holding the fill bank and in_ready=0.

Test Plan:
- Single batch: feed 1..7 back-to-back with op_ready=1 → start high exactly 2 cycles after word 7 for 1 cycle; operands = {7,6,5,4,3,2,1} (op0 = 1 in low bits); busy 1 until done_next; batch_count=1.
- Prefill during run: feed 10..16 while in L_RUN → in_ready drops after 16th word; operands stay 1..7 until done_next; second start occurs on the first op_ready cycle after done_next with operands 10..16.
- Backpressure/gaps: toggle in_valid randomly, hold op_ready=0 for 20 cycles after fill → no start, in_ready=0, fill bank intact; raise op_ready → start within 2 cycles.
- Reset mid-fill: accept 4 words, assert rst low 1 cycle → wr_idx=0, outputs zero; 7 new words → operands hold only the new words.
- Reset mid-run: rst low in L_RUN → busy=0, start=0, operands=0, batch_count=0.
- Spurious done_next in L_IDLE → protocol_err=1 and sticky; batch_count unchanged. With CNT_W=2, 5 batches → batch_count=1.
